// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared widths, depth and typedefs for the RAM-backed FIFO controller
package ram_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;
    typedef logic [DEF_ADDR_WIDTH:0]   cnt_t;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping address pointer with increment enable and sync reset
module fifo_ptr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    // Natural binary wrap from 2^WIDTH-1 back to 0 matches the power-of-two RAM depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller sequencing an external dual-port RAM with 1-cycle read
// Optional sticky overflow/underflow outputs enabled by FIFO_ERR_FLAGS_EN.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic                  push_acc;
    logic                  pop_acc;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;
    assign count    = cnt_q;

    assign ram_we    = push_acc;
    assign ram_waddr = wr_ptr;
    assign ram_wdata = push_data;

    // The RAM registers mem[rd_ptr] on the pop edge, so data simply passes through a cycle later.
    assign ram_raddr = rd_ptr;
    assign pop_data  = ram_rdata;

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_acc;
            case ({push_acc, pop_acc})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - queue-model checked bench for ram_fifo_ctrl with an attached RAM model
module tb_ram_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int NDEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic          full, empty, pop_valid, ram_we;
    logic [DW-1:0] pop_data, ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW:0]   count;
    logic [AW-1:0] ram_waddr, ram_raddr;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow, underflow;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .empty     (empty),
        .count     (count),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    // Dual-port RAM: write port A, registered read port B.
    logic [DW-1:0] mem [NDEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words plus running accept totals.
    int  q[$];
    bit  exp_valid = 0;
    int  exp_data = 0;
    int  n_push = 0;
    int  n_pop = 0;
    bit  exp_ovf = 0;
    bit  exp_udf = 0;
    bit  started = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_valid = 0;
            n_push = 0;
            n_pop = 0;
            exp_ovf = 0;
            exp_udf = 0;
        end else begin
            bit pa, pp;
            pa = push && (q.size() < NDEPTH);
            pp = pop && (q.size() > 0);
            if (push && q.size() == NDEPTH) exp_ovf = 1;
            if (pop && q.size() == 0) exp_udf = 1;
            exp_valid = pp;
            if (pp) begin
                exp_data = q.pop_front();
                n_pop++;
            end
            if (pa) begin
                q.push_back(int'(push_data));
                n_push++;
            end
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == NDEPTH));
            chk("pop_valid", 32'(pop_valid), 32'(exp_valid));
            if (exp_valid) chk("pop_data", 32'(pop_data), 32'(exp_data));
            chk("ram_we", 32'(ram_we), 32'(push && q.size() < NDEPTH));
            if (ram_we) chk("ram_wdata", 32'(ram_wdata), 32'(push_data));
            chk("ram_waddr", 32'(ram_waddr), 32'(n_push % NDEPTH));
            chk("ram_raddr", 32'(ram_raddr), 32'(n_pop % NDEPTH));
`ifdef FIFO_ERR_FLAGS_EN
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("underflow", 32'(underflow), 32'(exp_udf));
`endif
        end
    end

    task automatic step(input logic p, input logic [DW-1:0] d, input logic o);
        push = p;
        push_data = d;
        pop = o;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    logic [DW-1:0] vec [4];

    initial begin
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        rst = 1'b0;
        started = 1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        step(0, 8'h00, 0);

        // Fill to full, then an overflowing push.
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            step(1, vec[i], 0);
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 32'd1);
        push = 1'b1; push_data = 8'h55; #1;
        chk("ovf_no_we", 32'(ram_we), 32'd0);
        step(1, 8'h55, 0);
        chk("ovf_count", 32'(count), 32'd4);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_flag", 32'(overflow), 32'd1);
`endif

        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1);
            chk("drain_valid", 32'(pop_valid), 32'd1);
            chk("drain_data", 32'(pop_data), 32'(vec[i]));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(0, 8'h00, 1);
        chk("udf_no_valid", 32'(pop_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("udf_flag", 32'(underflow), 32'd1);
`endif

        // Wrap: pointers sit at 3 before the 0xA0 burst.
        for (int i = 0; i < 3; i++) step(1, 8'(i + 1), 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 8'hA0 + 8'(i), 0);
            if (i == 0) chk("wrap_waddr", 32'(ram_waddr), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1);
            chk("wrap_data", 32'(pop_data), 32'hA0 + 32'(i));
        end

        // Simultaneous push/pop at count=2.
        step(1, 8'hB1, 0);
        step(1, 8'hB2, 0);
        step(1, 8'hB3, 1);
        chk("sim2_count", 32'(count), 32'd2);
        chk("sim2_data", 32'(pop_data), 32'hB1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        chk("sim2_tail", 32'(pop_data), 32'hB3);

        // Simultaneous at full: push dropped.
        for (int i = 0; i < 4; i++) step(1, 8'hC1 + 8'(i), 0);
        step(1, 8'hC5, 1);
        chk("simf_count", 32'(count), 32'd3);
        chk("simf_data", 32'(pop_data), 32'hC1);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1);
            chk("simf_drain", 32'(pop_data), 32'hC2 + 32'(i));
        end
        chk("simf_empty", 32'(empty), 32'd1);

        // Simultaneous at empty: only the push lands.
        step(1, 8'hD1, 1);
        chk("sime_count", 32'(count), 32'd1);
        chk("sime_no_valid", 32'(pop_valid), 32'd0);
        step(0, 8'h00, 1);
        chk("sime_data", 32'(pop_data), 32'hD1);

        // Reset right after an accepted pop.
        step(1, 8'hE1, 0);
        step(1, 8'hE2, 0);
        step(0, 8'h00, 1);
        rst = 1'b1;
        step(0, 8'h00, 0);
        rst = 1'b0;
        chk("rst_mid_valid", 32'(pop_valid), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_empty", 32'(empty), 32'd1);
        step(1, 8'h5A, 0);
        step(0, 8'h00, 1);
        chk("post_rst_valid", 32'(pop_valid), 32'd1);
        chk("post_rst_data", 32'(pop_data), 32'h5A);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
